// File: rtl/jk_arb_pkg.sv
// Shared definitions for jk_register_arbiter: FSM state encoding and the
// per-bit JK next-state function applied to the shared register bank.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE  = 2'd1,
        LOCKED = 2'd2
    } jk_arb_state_e;

    // One JK flip-flop: J sets, K clears, both toggle, neither holds.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting at pointer and
// returns a one-hot grant plus the index of the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic                       valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // First requester at or after pointer, wrapping past NUM_REQ-1 back to 0.
    always_comb begin
        gnt    = '0;
        index  = '0;
        valid  = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s  = {1'b0, pointer} + (IDX_W+1)'(off);
            cand_s = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum_s - (IDX_W+1)'(NUM_REQ))
                                                    : sum_s[IDX_W-1:0];
            hit_s         = ~valid & req[cand_s];
            gnt[cand_s]   = gnt[cand_s] | hit_s;
            index         = hit_s ? cand_s : index;
            valid         = valid | hit_s;
        end
    end

endmodule

// File: rtl/jk_register_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit JK register bank among NUM_REQ
// requesters. Define JK_ARB_LOCK_EN to add the lock port and LOCKED state.
module jk_register_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] j_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] k_in,
`ifdef JK_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [WIDTH-1:0]              q,
    output logic                          upd,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || LOCK_MAX < 1) begin : g_bad_params
        $error("jk_register_arbiter: NUM_REQ must be 2..16 and LOCK_MAX >= 1");
    end

    jk_arb_state_e    state_r, state_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [WIDTH-1:0] q_r, q_next_s;
    logic             upd_r;
    logic [IDX_W-1:0] owner_r;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_valid_s;
    logic               sel_valid_s;
    logic [IDX_W-1:0]   sel_idx_s;

`ifdef JK_ARB_LOCK_EN
    localparam int               CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCK_MAX - 1);

    logic [IDX_W-1:0] lock_idx_r, lock_idx_s;
    logic [CNT_W-1:0] lock_cnt_r, lock_cnt_s;
`endif

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req),
        .pointer (ptr_r),
        .gnt     (arb_gnt_s),
        .index   (arb_idx_s),
        .valid   (arb_valid_s)
    );

    // FSM next state, grant selection and pointer advance.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        gnt         = '0;
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
`ifdef JK_ARB_LOCK_EN
        lock_idx_s  = lock_idx_r;
        lock_cnt_s  = lock_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = SERVE;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE: begin
                gnt         = arb_gnt_s;
                sel_valid_s = arb_valid_s;
                sel_idx_s   = arb_idx_s;
                if (arb_valid_s) begin
                    ptr_s = wrap_inc(arb_idx_s);
`ifdef JK_ARB_LOCK_EN
                    // A lock that can only ever last one grant never enters LOCKED.
                    if (lock[arb_idx_s] && (LOCK_MAX > 1)) begin
                        state_s    = LOCKED;
                        lock_idx_s = arb_idx_s;
                        lock_cnt_s = CNT_W'(1);
                    end else begin
                        state_s = SERVE;
                    end
`else
                    state_s = SERVE;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef JK_ARB_LOCK_EN
            LOCKED: begin
                if (req[lock_idx_r]) begin
                    gnt[lock_idx_r] = 1'b1;
                    sel_valid_s     = 1'b1;
                    sel_idx_s       = lock_idx_r;
                    ptr_s           = wrap_inc(lock_idx_r);
                    lock_cnt_s      = lock_cnt_r + CNT_W'(1);
                    if (!lock[lock_idx_r] || (lock_cnt_r == LAST_CNT)) begin
                        state_s = SERVE;
                    end else begin
                        state_s = LOCKED;
                    end
                end else begin
                    state_s = SERVE;
                end
            end
`endif
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next value of the bank under the selected requester's masks.
    always_comb begin
        q_next_s = q_r;
        for (int b = 0; b < WIDTH; b++) begin
            q_next_s[b] = jk_next(j_in[sel_idx_s][b], k_in[sel_idx_s][b], q_r[b]);
        end
    end

    // State, pointer, register bank and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            q_r     <= '0;
            upd_r   <= 1'b0;
            owner_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            upd_r   <= sel_valid_s;
            if (sel_valid_s) begin
                q_r     <= q_next_s;
                owner_r <= sel_idx_s;
            end
        end
    end

`ifdef JK_ARB_LOCK_EN
    // Lock holder and its consecutive-grant count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_idx_r <= '0;
            lock_cnt_r <= '0;
        end else begin
            lock_idx_r <= lock_idx_s;
            lock_cnt_r <= lock_cnt_s;
        end
    end
`endif

    assign q     = q_r;
    assign upd   = upd_r;
    assign owner = owner_r;

endmodule

// File: tb/tb_jk_register_arbiter.sv
// Self-checking bench for jk_register_arbiter (NUM_REQ=4, WIDTH=32, LOCK_MAX=8);
// the lock scenario is built only when JK_ARB_LOCK_EN is defined.
module tb_jk_register_arbiter;
    import jk_arb_pkg::*;

    localparam int LOCK_MAX_TB = 8;

    typedef struct {
        logic        u;
        logic [31:0] q;
        logic [1:0]  o;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [3:0]        req;
    logic [3:0][31:0]  j_in;
    logic [3:0][31:0]  k_in;
`ifdef JK_ARB_LOCK_EN
    logic [3:0]        lock;
`endif
    logic [3:0]        gnt;
    logic [31:0]       q;
    logic              upd;
    logic [1:0]        owner;

    int n_pass  = 0;
    int n_total = 0;

    exp_t          sb[$];
    exp_t          mon_e;
    jk_arb_state_e m_state;
    logic [1:0]    m_p;
    logic [1:0]    m_lidx;
    int            m_lcnt;
    logic [31:0]   m_q;
    logic [1:0]    m_owner;

    jk_register_arbiter #(.NUM_REQ(4), .WIDTH(32), .LOCK_MAX(LOCK_MAX_TB)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .j_in  (j_in),
        .k_in  (k_in),
`ifdef JK_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .q     (q),
        .upd   (upd),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit JK truth table: 00 hold, 01 clear, 10 set, 11 toggle.
    function automatic logic [31:0] jk_model(input logic [31:0] j, input logic [31:0] k,
                                             input logic [31:0] qo);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) begin
            case ({j[b], k[b]})
                2'b00:   r[b] = qo[b];
                2'b01:   r[b] = 1'b0;
                2'b10:   r[b] = 1'b1;
                default: r[b] = ~qo[b];
            endcase
        end
        return r;
    endfunction

    // Scoreboard: one expected entry per modelled edge, popped just after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_total++;
            if (upd !== mon_e.u) $display("FAIL sb_upd: got %b want %b", upd, mon_e.u);
            else n_pass++;
            n_total++;
            if (q !== mon_e.q) $display("FAIL sb_q: got %h want %h", q, mon_e.q);
            else n_pass++;
            n_total++;
            if (owner !== mon_e.o) $display("FAIL sb_owner: got %0d want %0d", owner, mon_e.o);
            else n_pass++;
        end
    end

    task automatic model_reset();
        m_state = IDLE;
        m_p     = 2'd0;
        m_lidx  = 2'd0;
        m_lcnt  = 0;
        m_q     = 32'h0;
        m_owner = 2'd0;
    endtask

    // Called at a negedge: drive req, sample gnt, model the next edge, end at next negedge.
    task automatic step(input logic [3:0] r, output logic [3:0] obs, output logic [3:0] eg);
        logic [1:0] gi;
        logic [1:0] c;
        req = r;
        #1;
        obs = gnt;
        eg  = 4'b0000;
        gi  = 2'd0;
        if (m_state == SERVE) begin
            for (int off = 0; off < 4; off++) begin
                c = m_p + 2'(off);
                if (eg == 4'b0000 && r[c]) begin
                    eg[c] = 1'b1;
                    gi    = c;
                end
            end
        end else if (m_state == LOCKED) begin
            if (r[m_lidx]) begin
                eg[m_lidx] = 1'b1;
                gi         = m_lidx;
            end
        end
        case (m_state)
            IDLE:  m_state = (r != 4'b0000) ? SERVE : IDLE;
            SERVE: begin
                if (eg == 4'b0000) m_state = IDLE;
`ifdef JK_ARB_LOCK_EN
                else if (lock[gi]) begin
                    m_state = LOCKED;
                    m_lidx  = gi;
                    m_lcnt  = 1;
                end
`endif
            end
            default: begin
                if (eg == 4'b0000) m_state = SERVE;
                else begin
                    m_lcnt++;
`ifdef JK_ARB_LOCK_EN
                    if (!lock[gi] || m_lcnt >= LOCK_MAX_TB) m_state = SERVE;
`endif
                end
            end
        endcase
        if (eg != 4'b0000) begin
            m_q     = jk_model(j_in[gi], k_in[gi], m_q);
            m_owner = gi;
            m_p     = gi + 2'd1;
            sb.push_back('{u: 1'b1, q: m_q, o: m_owner});
        end else begin
            sb.push_back('{u: 1'b0, q: m_q, o: m_owner});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 4'b0000;
`ifdef JK_ARB_LOCK_EN
        lock  = 4'b0000;
`endif
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [3:0] obs, eg;
        req = 4'b1111;
        j_in = '0;
        k_in = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (q !== 32'h0) $display("FAIL reset_q: got %h want 0", q); else n_pass++;
        n_total++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++;
        if (upd !== 1'b0) $display("FAIL reset_upd: got %b want 0", upd); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(4'b1111, obs, eg);
        n_total++;
        if (obs !== 4'b0000) $display("FAIL reset_idle_gnt: got %b want 0000", obs); else n_pass++;
        step(4'b1111, obs, eg);
        n_total++;
        if (obs !== 4'b0001) $display("FAIL reset_first_gnt: got %b want 0001", obs); else n_pass++;
    endtask

    task automatic test_toggle();
        logic [3:0] obs, eg;
        do_reset();
        j_in[1] = 32'hFFFF_FFFF;
        k_in[1] = 32'hFFFF_FFFF;
        step(4'b0010, obs, eg);
        for (int c = 0; c < 3; c++) begin
            step(4'b0010, obs, eg);
            n_total++;
            if (obs !== 4'b0010) $display("FAIL toggle_gnt%0d: got %b want 0010", c, obs); else n_pass++;
            n_total++;
            if (q !== ((c % 2 == 0) ? 32'hFFFF_FFFF : 32'h0))
                $display("FAIL toggle_q%0d: got %h", c, q);
            else n_pass++;
            n_total++;
            if (upd !== 1'b1) $display("FAIL toggle_upd%0d: got %b want 1", c, upd); else n_pass++;
        end
        step(4'b0000, obs, eg);
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, eg;
        logic [1:0] ow;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            j_in[i] = $urandom;
            k_in[i] = $urandom;
        end
        step(4'b1111, obs, eg);
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, obs, eg);
            ow = 2'(c % 4);
            n_total++;
            if (obs !== (4'b0001 << ow)) $display("FAIL b2b_gnt%0d: got %b want %0d", c, obs, ow);
            else n_pass++;
            n_total++;
            if (owner !== ow) $display("FAIL b2b_owner%0d: got %0d want %0d", c, owner, ow);
            else n_pass++;
        end
        step(4'b0000, obs, eg);
    endtask

    task automatic test_masks();
        logic [3:0] obs, eg;
        do_reset();
        j_in[0] = 32'h0000_FFFF;
        k_in[0] = 32'h0;
        j_in[2] = 32'hFF00_0000;
        k_in[2] = 32'h0000_00FF;
        step(4'b0001, obs, eg);
        step(4'b0001, obs, eg);
        n_total++;
        if (q !== 32'h0000_FFFF) $display("FAIL masks_pre: got %h want 0000ffff", q); else n_pass++;
        step(4'b0100, obs, eg);
        n_total++;
        if (obs !== 4'b0100) $display("FAIL masks_gnt: got %b want 0100", obs); else n_pass++;
        n_total++;
        if (q !== 32'hFF00_FF00) $display("FAIL masks_q: got %h want ff00ff00", q); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            step(4'b0000, obs, eg);
            n_total++;
            if (q !== 32'hFF00_FF00 || upd !== 1'b0)
                $display("FAIL idle_hold%0d: got q=%h upd=%b want ff00ff00/0", c, q, upd);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        logic [3:0] obs, eg;
        do_reset();
        step(4'b1010, obs, eg);
        step(4'b1010, obs, eg);
        n_total++;
        if (obs !== 4'b0010) $display("FAIL drop_first: got %b want 0010", obs); else n_pass++;
        step(4'b0100, obs, eg);
        n_total++;
        if (obs !== 4'b0100) $display("FAIL drop_second: got %b want 0100", obs); else n_pass++;
        step(4'b0000, obs, eg);
    endtask

    task automatic test_midreset();
        logic [3:0] obs, eg;
        do_reset();
        j_in[0] = 32'h1234_5678;
        k_in[0] = 32'h0;
        j_in[1] = 32'hFFFF_FFFF;
        k_in[1] = 32'hFFFF_FFFF;
        step(4'b0001, obs, eg);
        step(4'b0001, obs, eg);
        n_total++;
        if (q !== 32'h1234_5678) $display("FAIL midrst_pre: got %h want 12345678", q); else n_pass++;
        req = 4'b0010;
        #1 reset = 1'b0;
        sb.delete();
        #1;
        n_total++;
        if (q !== 32'h0 || upd !== 1'b0 || gnt !== 4'b0000)
            $display("FAIL midrst_clear: got q=%h upd=%b gnt=%b want 0/0/0000", q, upd, gnt);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(4'b1111, obs, eg);
        step(4'b1111, obs, eg);
        n_total++;
        if (obs !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", obs); else n_pass++;
        step(4'b0000, obs, eg);
    endtask

`ifdef JK_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] obs, eg;
        do_reset();
        lock = 4'b1000;
        step(4'b1111, obs, eg);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, obs, eg);
            n_total++;
            if (obs !== eg) $display("FAIL lock_pre%0d: got %b want %b", c, obs, eg); else n_pass++;
        end
        for (int c = 0; c < LOCK_MAX_TB; c++) begin
            step(4'b1111, obs, eg);
            n_total++;
            if (obs !== 4'b1000) $display("FAIL lock_hold%0d: got %b want 1000", c, obs); else n_pass++;
        end
        step(4'b1111, obs, eg);
        n_total++;
        if (obs !== 4'b0001) $display("FAIL lock_exit: got %b want 0001", obs); else n_pass++;
        lock = 4'b0000;
        step(4'b0000, obs, eg);
    endtask
`endif

    initial begin
        req   = 4'b0000;
        j_in  = '0;
        k_in  = '0;
        reset = 1'b1;
`ifdef JK_ARB_LOCK_EN
        lock  = 4'b0000;
`endif
        model_reset();
        test_reset();
        test_toggle();
        test_back_to_back();
        test_masks();
        test_drop();
        test_midreset();
`ifdef JK_ARB_LOCK_EN
        test_lock();
`endif
        @(posedge clk);
        #2;
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d entries want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
